// File: rtl/rtc_reader_pkg.sv
// rtc_reader_pkg: RTC register map, reader FSM states, error codes and snapshot layout.
package rtc_reader_pkg;

    localparam logic [31:0] CUR_SEC_REG   = 32'h0000_0000;
    localparam logic [31:0] CUR_MIN_REG   = 32'h0000_0004;
    localparam logic [31:0] CUR_HOURS_REG = 32'h0000_0008;
    localparam logic [31:0] CUR_DOW_REG   = 32'h0000_000C;
    localparam logic [31:0] CUR_DOM_REG   = 32'h0000_0010;
    localparam logic [31:0] CUR_MONTH_REG = 32'h0000_0014;
    localparam logic [31:0] CUR_YEAR_REG  = 32'h0000_0018;

    // Slot 7 re-reads seconds to detect a roll-over during the sequence
    localparam logic [31:0] ADDR_TBL [0:7] = '{
        CUR_SEC_REG, CUR_MIN_REG, CUR_HOURS_REG, CUR_DOW_REG,
        CUR_DOM_REG, CUR_MONTH_REG, CUR_YEAR_REG, CUR_SEC_REG
    };

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CHECK, DONE, ERR} state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SLVERR  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_RETRY   = 2'b11;

    typedef struct packed {
        logic [5:0]  sec;
        logic [5:0]  min;
        logic [7:0]  hours;
        logic [2:0]  dow;
        logic [4:0]  dom;
        logic [3:0]  month;
        logic [11:0] year;
    } snap_t;

endpackage

// File: rtl/apb_read_master.sv
// apb_read_master: single APB read (SETUP then ACCESS) with a bounded PREADY wait.
module apb_read_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK_APB,
    input  logic        rstn_i,
    input  logic        req,
    input  logic [31:0] addr,
    output logic        done,
    output logic [31:0] rdata,
    output logic        slverr,
    output logic        timeout,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [31:0] PADDR,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign done    = PENABLE && PREADY;
    assign slverr  = done && PSLVERR;
    assign timeout = PENABLE && !PREADY && cnt == CW'(TIMEOUT - 1);
    assign rdata   = PRDATA;

    // A new req wins over completion so back-to-back reads re-enter SETUP
    always_ff @(posedge CLK_APB) begin
        if (!rstn_i) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            cnt     <= '0;
        end else if (req) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= addr;
            cnt     <= '0;
        end else if (PSEL && !PENABLE) begin
            PENABLE <= 1'b1;
        end else if (done || timeout) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end else if (PENABLE) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rtc_snapshot_reader.sv
// rtc_snapshot_reader: reads the seven RTC time registers over APB and publishes
// a coherent snapshot, retrying the sequence when seconds change mid-read.
module rtc_snapshot_reader
    import rtc_reader_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic        CLK_APB,
    input  logic        rstn_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [1:0]  err_o,
    output logic [5:0]  sec_o,
    output logic [5:0]  min_o,
    output logic [7:0]  hours_o,
    output logic [2:0]  dow_o,
    output logic [4:0]  dom_o,
    output logic [3:0]  month_o,
    output logic [11:0] year_o,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t        state, state_n;
    logic [2:0]    idx;
    logic [RW-1:0] retry;
    snap_t         shadow, snap;
    logic [5:0]    resec;
    logic [31:0]   addr, rdata;
    logic [1:0]    err_n;
    logic          req, done, slverr, timeout, match;

    assign addr    = ADDR_TBL[state == ACCESS ? idx + 3'd1 : 3'd0];
    assign match   = resec == shadow.sec;
    assign busy_o  = state != IDLE;
    assign valid_o = state == DONE;
    assign PWRITE  = 1'b0;
    assign PWDATA  = '0;
    assign {sec_o, min_o, hours_o, dow_o, dom_o, month_o, year_o} = snap;

    apb_read_master #(.TIMEOUT(TIMEOUT)) u_apb (
        .CLK_APB (CLK_APB),
        .rstn_i  (rstn_i),
        .req     (req),
        .addr    (addr),
        .done    (done),
        .rdata   (rdata),
        .slverr  (slverr),
        .timeout (timeout),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PADDR   (PADDR),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always_comb begin
        state_n = state;
        req     = 1'b0;
        err_n   = ERR_NONE;
        case (state)
            IDLE: begin
                state_n = start_i ? SETUP : IDLE;
                req     = start_i;
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (slverr) begin
                    state_n = ERR;
                    err_n   = ERR_SLVERR;
                end else if (done) begin
                    state_n = idx == 3'd7 ? CHECK : SETUP;
                    req     = idx != 3'd7;
                end else if (timeout) begin
                    state_n = ERR;
                    err_n   = ERR_TIMEOUT;
                end
            end
            CHECK: begin
                if (match) begin
                    state_n = DONE;
                end else if (retry < RW'(MAX_RETRY)) begin
                    state_n = SETUP;
                    req     = 1'b1;
                end else begin
                    state_n = ERR;
                    err_n   = ERR_RETRY;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK_APB) begin
        if (!rstn_i) begin
            state  <= IDLE;
            idx    <= '0;
            retry  <= '0;
            err_o  <= ERR_NONE;
            shadow <= '0;
            resec  <= '0;
            snap   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start_i) begin
                idx   <= '0;
                retry <= '0;
                err_o <= ERR_NONE;
            end
            if (state_n == ERR)
                err_o <= err_n;
            if (done && !slverr) begin
                idx <= idx + 3'd1;
                case (idx)
                    3'd0:    shadow.sec   <= rdata[5:0];
                    3'd1:    shadow.min   <= rdata[5:0];
                    3'd2:    shadow.hours <= rdata[7:0];
                    3'd3:    shadow.dow   <= rdata[2:0];
                    3'd4:    shadow.dom   <= rdata[4:0];
                    3'd5:    shadow.month <= rdata[3:0];
                    3'd6:    shadow.year  <= rdata[11:0];
                    default: resec        <= rdata[5:0];
                endcase
            end
            if (state == CHECK) begin
                idx <= '0;
                if (!match)
                    retry <= retry + 1'b1;
                else
                    snap <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_rtc_snapshot_reader.sv
// tb_rtc_snapshot_reader: APB slave model with a scripted RTC time schedule and a
// read-sequence reference model predicting snapshot, error code and cycle count.
module tb_rtc_snapshot_reader;

    logic        clk = 1'b0, rstn_i = 1'b0, start_i = 1'b0;
    logic        busy_o, valid_o, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [1:0]  err_o;
    logic [5:0]  sec_o, min_o;
    logic [7:0]  hours_o;
    logic [2:0]  dow_o;
    logic [4:0]  dom_o;
    logic [3:0]  month_o;
    logic [11:0] year_o;
    logic [31:0] PADDR, PWDATA, PRDATA;

    int total = 0, bad = 0;

    logic [31:0] cur [0:7];
    logic [31:0] nxt [0:7];
    int          tick_at, waits, err_idx, base = 0;
    bit          spin, stuck;
    int          nrd = 0, wcnt = 0, stab_err = 0, ridx, rel;
    logic [31:0] setup_addr = '0;
    logic [31:0] rlog [$];
    logic [43:0] exp_snap = '0;

    always #5 clk = ~clk;

    rtc_snapshot_reader dut (
        .CLK_APB (clk),
        .rstn_i  (rstn_i),
        .start_i (start_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .sec_o   (sec_o),
        .min_o   (min_o),
        .hours_o (hours_o),
        .dow_o   (dow_o),
        .dom_o   (dom_o),
        .month_o (month_o),
        .year_o  (year_o),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    // Slave: register word i lives at 4*i; data flips to nxt after tick_at reads
    always_comb begin
        ridx    = int'(PADDR[4:2]);
        rel     = nrd - base;
        PRDATA  = (spin && ridx == 0) ? 32'(rel) : (rel >= tick_at ? nxt[ridx] : cur[ridx]);
        PREADY  = PSEL && PENABLE && !stuck && wcnt >= waits;
        PSLVERR = PREADY && ridx == err_idx;
    end

    always @(posedge clk) begin
        if (PSEL && !PENABLE)
            setup_addr <= PADDR;
        if (PSEL && PENABLE) begin
            if (PADDR != setup_addr || PWRITE || PWDATA != 32'h0)
                stab_err <= stab_err + 1;
            wcnt <= PREADY ? 0 : wcnt + 1;
            if (PREADY) begin
                rlog.push_back(PADDR);
                nrd <= nrd + 1;
            end
        end else begin
            wcnt <= 0;
            if (PENABLE)
                stab_err <= stab_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int n, input int r);
        if (spin && r == 0)
            return 32'(n);
        return n >= tick_at ? nxt[r] : cur[r];
    endfunction

    // Walk the read attempts: 8 reads (+waits) then a check cycle each; publish on match
    task automatic model(output bit ok, output logic [1:0] e, output int tend, output int n,
                         output logic [43:0] snap);
        logic [31:0] v [0:7];
        int t, r;
        t = 0; n = 0; ok = 0; e = 2'b00; snap = exp_snap;
        for (int a = 0; a < 4; a++) begin
            for (int i = 0; i < 8; i++) begin
                r = i % 7;
                if (stuck) begin
                    tend = t + 18;
                    e = 2'b10;
                    return;
                end
                v[i] = word(n, r);
                n++;
                t += 2 + waits;
                if (r == err_idx) begin
                    tend = t + 1;
                    e = 2'b01;
                    return;
                end
            end
            t += 1;
            if (v[7][5:0] == v[0][5:0]) begin
                ok = 1;
                tend = t + 1;
                snap = {v[0][5:0], v[1][5:0], v[2][7:0], v[3][2:0], v[4][4:0], v[5][3:0], v[6][11:0]};
                return;
            end
        end
        tend = t + 1;
        e = 2'b11;
    endtask

    task automatic plain(input int w);
        waits = w; tick_at = 1 << 30; err_idx = 7; spin = 0; stuck = 0;
    endtask

    task automatic set_t(input bit which, input int s, input int mi, input int h, input int dw,
                         input int dm, input int mo, input int y);
        int v [0:6];
        v = '{s, mi, h, dw, dm, mo, y};
        for (int i = 0; i < 7; i++) begin
            if (which) nxt[i] = (32'($urandom) << 12) | 32'(v[i]);
            else       cur[i] = (32'($urandom) << 12) | 32'(v[i]);
        end
    endtask

    task automatic run(input string tag);
        bit ok;
        logic [1:0] e;
        logic [43:0] snap;
        int tend, en, bc, vc, t, lb, sb, nb;
        model(ok, e, tend, en, snap);
        lb = rlog.size(); sb = stab_err; bc = 0; vc = 0; t = 0; nb = 0;
        @(negedge clk);
        base = nrd;
        start_i = 1;
        @(posedge clk);
        #1 start_i = 0;
        while (t < 400) begin
            @(negedge clk);
            t++;
            if (t == 1) chk({tag, ":errclr"}, err_o, 0);
            if (!busy_o) break;
            bc++;
            if (valid_o) vc++;
            start_i = $urandom_range(3) == 0;
        end
        start_i = 0;
        chk({tag, ":bound"}, t < 400, 1);
        chk({tag, ":cycles"}, bc, tend);
        chk({tag, ":valid"}, vc, ok);
        chk({tag, ":err"}, err_o, e);
        if (ok) exp_snap = snap;
        chk({tag, ":snap"}, {sec_o, min_o, hours_o, dow_o, dom_o, month_o, year_o}, exp_snap);
        chk({tag, ":reads"}, rlog.size() - lb, en);
        for (int i = 0; i < en && lb + i < rlog.size(); i++)
            if (rlog[lb + i] != 32'(4 * ((i % 8) % 7))) nb++;
        chk({tag, ":addr"}, nb, 0);
        chk({tag, ":proto"}, stab_err - sb, 0);
    endtask

    initial begin
        plain(0);
        cur[7] = '0; nxt[7] = '0;
        set_t(0, 0, 0, 0, 0, 0, 0, 0);
        set_t(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset:ctl", {PSEL, PENABLE, busy_o, valid_o, err_o, PADDR}, 0);
        chk("reset:snap", {sec_o, min_o, hours_o, dow_o, dom_o, month_o, year_o}, 0);
        @(negedge clk) rstn_i = 1;

        set_t(0, 56, 34, 12, 1, 15, 6, 2024);
        run("basic");

        set_t(0, 59, 59, 23, 7, 31, 12, 2000);
        set_t(1, 0, 0, 0, 1, 1, 1, 2001);
        tick_at = 1;
        run("rollover");

        plain(3);
        set_t(0, 56, 34, 12, 1, 15, 6, 2024);
        run("wait3");

        plain(0);
        set_t(0, 5, 6, 7, 2, 3, 4, 1999);
        err_idx = 4;
        run("slverr");

        plain(0);
        stuck = 1;
        run("timeout");

        plain(0);
        spin = 1;
        run("retries");

        plain(0);
        @(negedge clk);
        start_i = 1;
        @(posedge clk);
        #1 start_i = 0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("rst:access4", {PSEL, PENABLE, PADDR}, {2'b11, 32'h0C});
        rstn_i = 0;
        @(posedge clk);
        #1;
        chk("rst:ctl", {PSEL, PENABLE, busy_o, valid_o, err_o, PADDR}, 0);
        chk("rst:snap", {sec_o, min_o, hours_o, dow_o, dom_o, month_o, year_o}, 0);
        @(negedge clk) rstn_i = 1;
        exp_snap = '0;

        set_t(0, 1, 2, 3, 4, 5, 6, 2025);
        run("post_rst");

        for (int k = 0; k < 24; k++) begin
            plain(int'($urandom_range(3)));
            for (int i = 0; i < 7; i++) begin
                cur[i] = $urandom;
                nxt[i] = $urandom;
            end
            tick_at = $urandom_range(1) == 1 ? int'($urandom_range(40)) : 1 << 30;
            err_idx = $urandom_range(7) == 0 ? int'($urandom_range(6)) : 7;
            stuck   = $urandom_range(15) == 0;
            spin    = $urandom_range(15) == 0;
            run($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
